hazard_fwd_tracker: RTL
=======================

Name: hazard_fwd_tracker

Overview:
Parametrised successor to the team's combinational forwarding and hazard-detection pair. It keeps its own registered in-flight table of the EX, MEM and WB stages, fed by the instruction issuing from ID. It resolves load-use, branch-in-ID and multi-cycle data-memory hazards, and produces ALU forward selects and branch-comparator forward selects. It also counts stall cycles for performance debug, and sits beside the ID/EX control path of the pipelined MIPS core.

Parameters:
AW, 5, register address width
NSRC, 2, source operands per instruction (operand 0 = rs, 1 = rt, ...)
CNT_W, 16, width of the saturating stall/flush counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_src  in  NSRC*AW  ID source addresses, operand i at [i*AW +: AW]
id_src_used  in  NSRC  operand i is read by the ID instruction
id_wr_en  in  1  ID instruction writes a register
id_rd  in  AW  ID destination address
id_is_load  in  1  ID instruction is a load
id_is_branch  in  1  ID instruction is a branch resolved in ID
br_taken  in  1  ID comparator result (valid when id_is_branch)
mem_ready  in  1  data memory done; a load in MEM waits while low
pc_write  out  1  PC may update
ifid_write  out  1  IF/ID may update
idex_bubble  out  1  insert bubble into ID/EX
ifid_flush  out  1  squash IF/ID
pc_sel  out  1  select branch target
fwd_sel  out  NSRC*2  per EX operand: 00 regfile, 01 EX/MEM, 10 MEM/WB
br_sel  out  NSRC*2  per ID operand: 00 regfile, 01 EX/MEM, 10 MEM/WB
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Tracker entries ex, mem, wb. Each entry holds v, wr, rd, ld, and src/src_used; only ex uses its sources.
- "Writer match" for address a against an entry: v & wr & (rd == a) & (a != 0).
- hold = mem.v & mem.ld & ~mem_ready.
- hold has the highest priority:
  - pc_write = 0, ifid_write = 0, idex_bubble = 0, ifid_flush = 0, pc_sel = 0.
  - All entries frozen.
  - stall_cnt increments.
- stall is computed when not in hold. For any used ID operand i with address a:
  - writer match on ex where ex.ld or id_is_branch, OR
  - writer match on mem where mem.ld and id_is_branch.
  - stall is qualified by id_valid.
- When stall (not hold): pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0, pc_sel = 0; stall_cnt increments.
- Otherwise: pc_write = 1, ifid_write = 1, idex_bubble = 0.
- Taken branch: if id_valid & id_is_branch & br_taken (and no stall or hold), then ifid_flush = 1 and pc_sel = 1 in the same cycle, and flush_cnt increments.
- Shift on every non-hold clock edge:
  - wb <= mem, mem <= ex.
  - ex <= ID fields with v = id_valid & ~stall & ~idex_bubble; on stall ex <= invalid.
- fwd_sel[i], from registered state, with EX/MEM priority:
  - 01 if ex.src_used[i] and writer match of ex.src[i] on mem with ~mem.ld.
  - Else 10 if writer match on wb.
  - Else 00.
  - A load in mem never produces 01; the stall rule guarantees the consumer waits.
- br_sel[i], combinational on ID: 01 if writer match on mem with ~mem.ld; else 10 if writer match on wb; else 00. Forced to 00 when ~id_is_branch.
- Simultaneous events: hold beats stall, and stall beats taken-branch. A branch stalled for a load commits its flush only on the cycle it is released.
- Counters saturate at all-ones, with no wrap.
- Reset (asynchronous): all entries v = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs during and after reset with id_valid = 0: pc_write = 1, ifid_write = 1, idex_bubble = 0, ifid_flush = 0, pc_sel = 0, fwd_sel = 0, br_sel = 0.
  - Reset asserted mid-stall or mid-hold clears the table immediately; the next cycle is unstalled.

Test Plan:
- lw r8 then add r9,r8,r2: one cycle pc_write = 0 / idex_bubble = 1, then add in EX with fwd_sel[0] = 10; stall_cnt = 1.
- add r8 then sub r9,r2,r8: no stall; sub in EX sees fwd_sel[1] = 01; add r0 as destination gives fwd_sel = 00.
- add r8 then beq r8,r3 taken: one stall, then br_sel[0] = 01, ifid_flush = 1, pc_sel = 1; flush_cnt = 1.
- lw r8 then beq r8,r0: two stall cycles, then br_sel[0] = 10; the branch is not taken, so no flush.
- lw in MEM with mem_ready low for 3 cycles: all write enables 0, tracker frozen, stall_cnt += 3, then normal advance.
- Assert reset during hold with stall_cnt = 0xFFFF (saturated earlier): counters return to 0 and pc_write = 1 the next cycle.

Source files
------------

// File: rtl/hazard_fwd_tracker.sv
// hazard_fwd_tracker: registered EX/MEM/WB writer table for the pipelined MIPS core.
// It resolves load-use, branch-in-ID and slow-data-memory hazards, and drives ALU and branch forward selects.
// It also keeps saturating stall/flush counters for performance debug.
// Ports: clk/reset (async, active high); id_* describe the instruction issuing from ID;
//        br_taken is the ID comparator result; mem_ready is low while a load in MEM waits on memory.
//        pc_write/ifid_write/idex_bubble/ifid_flush/pc_sel are pipeline controls.
//        fwd_sel (EX operands) and br_sel (ID operands) are 2 bits per operand: 00 regfile, 01 EX/MEM, 10 MEM/WB.
//        stall_cnt/flush_cnt are the debug counters.
module hazard_fwd_tracker #(
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic                 id_wr_en,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_is_load,
    input  logic                 id_is_branch,
    input  logic                 br_taken,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic                 pc_sel,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic [NSRC*2-1:0]    br_sel,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // In-flight table. Only the EX entry keeps its sources (for fwd_sel).
    logic                ex_v, ex_wr, ex_ld;
    logic [AW-1:0]       ex_rd;
    logic [NSRC*AW-1:0]  ex_src;
    logic [NSRC-1:0]     ex_src_used;
    logic                mem_v, mem_wr, mem_ld;
    logic [AW-1:0]       mem_rd;
    logic                wb_v, wb_wr;
    logic [AW-1:0]       wb_rd;

    logic hold, stall, raw_stall, taken;

    // r0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic wmatch(input logic v, input logic wr,
                                    input logic [AW-1:0] rd, input logic [AW-1:0] a);
        return v & wr & (rd == a) & (a != '0);
    endfunction

    always_comb begin
        hold      = mem_v & mem_ld & ~mem_ready;
        raw_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i]) begin
                // ALU consumers wait only for a load in EX; a branch compares in ID,
                // so it also waits for any ALU result in EX and for a load still in MEM.
                if (wmatch(ex_v, ex_wr, ex_rd, id_src[i*AW +: AW]) && (ex_ld || id_is_branch))
                    raw_stall = 1'b1;
                if (wmatch(mem_v, mem_wr, mem_rd, id_src[i*AW +: AW]) && mem_ld && id_is_branch)
                    raw_stall = 1'b1;
            end
        end
        stall = id_valid & raw_stall & ~hold;
        taken = id_valid & id_is_branch & br_taken & ~raw_stall & ~hold;
    end

    // Forward selects: EX/MEM has priority over MEM/WB; a load in MEM has no data yet.
    always_comb begin
        fwd_sel = '0;
        br_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_src_used[i]) begin
                if (wmatch(mem_v, mem_wr, mem_rd, ex_src[i*AW +: AW]) && !mem_ld)
                    fwd_sel[i*2 +: 2] = 2'b01;
                else if (wmatch(wb_v, wb_wr, wb_rd, ex_src[i*AW +: AW]))
                    fwd_sel[i*2 +: 2] = 2'b10;
            end
            if (id_is_branch) begin
                if (wmatch(mem_v, mem_wr, mem_rd, id_src[i*AW +: AW]) && !mem_ld)
                    br_sel[i*2 +: 2] = 2'b01;
                else if (wmatch(wb_v, wb_wr, wb_rd, id_src[i*AW +: AW]))
                    br_sel[i*2 +: 2] = 2'b10;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pc_sel      = 1'b0;
        if (hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (taken) begin
            ifid_flush = 1'b1;
            pc_sel     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v        <= 1'b0;
            ex_wr       <= 1'b0;
            ex_ld       <= 1'b0;
            ex_rd       <= '0;
            ex_src      <= '0;
            ex_src_used <= '0;
            mem_v       <= 1'b0;
            mem_wr      <= 1'b0;
            mem_ld      <= 1'b0;
            mem_rd      <= '0;
            wb_v        <= 1'b0;
            wb_wr       <= 1'b0;
            wb_rd       <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if ((hold || stall) && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (ifid_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_ONE;
            if (!hold) begin
                wb_v   <= mem_v;
                wb_wr  <= mem_wr;
                wb_rd  <= mem_rd;
                mem_v  <= ex_v;
                mem_wr <= ex_wr;
                mem_ld <= ex_ld;
                mem_rd <= ex_rd;
                // A bubble enters EX with its source-use bits cleared so it never forwards.
                ex_v        <= id_valid & ~stall;
                ex_wr       <= id_wr_en;
                ex_ld       <= id_is_load;
                ex_rd       <= id_rd;
                ex_src      <= id_src;
                ex_src_used <= id_src_used & {NSRC{id_valid & ~stall}};
            end
        end
    end
endmodule
